// File: rtl/data_memory_boot_ctrl_pkg.sv
// rtl/data_memory_boot_ctrl_pkg.sv - shared types and constants for the data memory boot controller
// Contents: controller state enum, default memory capacity, byte width.

package data_memory_boot_ctrl_pkg;

    localparam int BYTE_W        = 8;
    localparam int MEM_BYTES_DEF = 1024;
    localparam int CNT_W_DEF     = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } boot_state_t;

endpackage

// File: rtl/data_memory_boot_ctrl_if.sv
// rtl/data_memory_boot_ctrl_if.sv - boot stream, memory and CPU access signals around the boot controller
// Signal groups:
//   boot source : src_valid, src_data, src_last (to controller), src_ready (from controller)
//   memory      : load, store, ready, mem_read, mem_write (from controller)
//   CPU         : cpu_mem_read, cpu_mem_write (to controller), cpu_stall (from controller)
// Modports: master = surrounding system (source, CPU, memory), slave = boot controller.

interface data_memory_boot_ctrl_if;
    import data_memory_boot_ctrl_pkg::*;

    logic              src_valid;
    logic [BYTE_W-1:0] src_data;
    logic              src_last;
    logic              src_ready;

    logic              load;
    logic [BYTE_W-1:0] store;
    logic              ready;
    logic              mem_read;
    logic              mem_write;

    logic              cpu_mem_read;
    logic              cpu_mem_write;
    logic              cpu_stall;

    modport master (
        output src_valid, src_data, src_last, cpu_mem_read, cpu_mem_write,
        input  src_ready, load, store, ready, mem_read, mem_write, cpu_stall
    );

    modport slave (
        input  src_valid, src_data, src_last, cpu_mem_read, cpu_mem_write,
        output src_ready, load, store, ready, mem_read, mem_write, cpu_stall
    );

endinterface

// File: rtl/data_memory_boot_ctrl.sv
// rtl/data_memory_boot_ctrl.sv - boot-load then run sequencer for the byte-wide data memory
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   boot_start   : single-cycle request to (re)start a boot load
//   bus          : slave side of data_memory_boot_ctrl_if (boot stream, memory port, CPU gating)
//   byte_count   : bytes issued to memory in the current or last boot (saturates at MEM_BYTES)
//   checksum     : modulo-256 sum of bytes issued in the current or last boot
//   boot_done    : one-cycle pulse on entry to the run phase
//   boot_error   : high while in the error state (image longer than MEM_BYTES)

module data_memory_boot_ctrl
    import data_memory_boot_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   boot_start,
    data_memory_boot_ctrl_if.slave bus,
    output logic [CNT_W-1:0]       byte_count,
    output logic [BYTE_W-1:0]      checksum,
    output logic                   boot_done,
    output logic                   boot_error
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_BYTES);

    boot_state_t state_q, state_d;

    logic              src_ready_q;
    logic              load_q;
    logic [BYTE_W-1:0] store_q;
    logic              ready_q;
    logic              cpu_stall_q;

    logic              beat;
    logic              overflow;
    logic              clear_d;
    logic [CNT_W-1:0]  count_d;
    logic [BYTE_W-1:0] sum_d;
    logic              src_ready_d;

    // src_ready_q is only ever high in LOAD, so a beat implies LOAD.
    assign beat     = bus.src_valid & src_ready_q;
    // Once the memory is full src_ready is already low; any further byte is an over-long image.
    assign overflow = (state_q == ST_LOAD) && bus.src_valid && (byte_count == CNT_MAX);

    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (boot_start) begin
                    state_d = ST_LOAD;
                    clear_d = 1'b1;
                end
            end
            ST_LOAD: begin
                // Overflow is checked first so that an over-long last byte still errors.
                if (overflow) begin
                    state_d = ST_ERROR;
                end else if (beat && bus.src_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (boot_start) begin
                    state_d = ST_LOAD;
                    clear_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = byte_count;
        sum_d   = checksum;
        if (clear_d) begin
            count_d = '0;
            sum_d   = '0;
        end else if (beat) begin
            count_d = (byte_count == CNT_MAX) ? CNT_MAX : byte_count + CNT_W'(1);
            sum_d   = checksum + bus.src_data;
        end
        // Registered handshake: look at the next count so src_ready falls right after the last fitting beat.
        src_ready_d = (state_d == ST_LOAD) && (count_d < CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ready_q <= 1'b0;
            load_q      <= 1'b0;
            store_q     <= '0;
            ready_q     <= 1'b0;
            cpu_stall_q <= 1'b1;
            byte_count  <= '0;
            checksum    <= '0;
            boot_done   <= 1'b0;
            boot_error  <= 1'b0;
        end else begin
            src_ready_q <= src_ready_d;
            load_q      <= beat;
            if (beat) begin
                store_q <= bus.src_data;
            end
            ready_q     <= (state_d == ST_RUN);
            cpu_stall_q <= (state_d != ST_RUN);
            byte_count  <= count_d;
            checksum    <= sum_d;
            boot_done   <= (state_d == ST_RUN) && (state_q != ST_RUN);
            boot_error  <= (state_d == ST_ERROR);
        end
    end

    assign bus.src_ready = src_ready_q;
    assign bus.load      = load_q;
    assign bus.store     = store_q;
    assign bus.ready     = ready_q;
    assign bus.cpu_stall = cpu_stall_q;
    // CPU accesses reach the memory only while it is in the run phase.
    assign bus.mem_read  = bus.cpu_mem_read & ready_q;
    assign bus.mem_write = bus.cpu_mem_write & ready_q;

endmodule

// File: doc/data_memory_boot_ctrl.md
Name: data_memory_boot_ctrl

Overview:
- Sequences the byte-wide data memory through two phases: a boot-load phase, then a run phase.
- Boot-load: accepts a byte stream from an external source over a valid/ready handshake and drives the memory's load/store preload port, one byte per accepted beat.
- Run: raises the memory's ready, gates the CPU's MemRead/MemWrite onto the memory and releases the CPU stall.
- Sits between the boot source, the CPU datapath control and data_memory.

Parameters:
- MEM_BYTES, 1024, capacity of the data memory in bytes; maximum accepted boot image length.
- CNT_W, 11, width of byte_count; must hold MEM_BYTES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- boot_start  in  1  single-cycle request to (re)start a boot load.
- src_valid  in  1  boot source byte valid.
- src_data  in  8  boot source byte.
- src_last  in  1  marks final byte of the image; qualified by src_valid.
- src_ready  out  1  controller accepts a byte this cycle.
- load  out  1  to memory: write store at the memory's internal sequential pointer.
- store  out  8  to memory: preload byte.
- ready  out  1  to memory: run phase, CPU accesses enabled.
- cpu_mem_read  in  1  CPU MemRead request.
- cpu_mem_write  in  1  CPU MemWrite request.
- mem_read  out  1  gated MemRead to memory.
- mem_write  out  1  gated MemWrite to memory.
- cpu_stall  out  1  holds the CPU pipeline while not in run phase.
- byte_count  out  CNT_W  bytes issued to memory in the current or last boot.
- checksum  out  8  modulo-256 sum of bytes issued in the current or last boot.
- boot_done  out  1  one-cycle pulse when run phase is entered.
- boot_error  out  1  held high in ERROR state.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: state IDLE. load=0, store=0, ready=0, src_ready=0, byte_count=0, checksum=0, boot_done=0, boot_error=0. cpu_stall=1, mem_read=0, mem_write=0.
- States: IDLE, LOAD, RUN, ERROR. All outputs except the combinational gating are registered.
- IDLE: src_ready=0. On boot_start: go to LOAD; clear byte_count and checksum.
- LOAD:
  - src_ready=1 while byte_count < MEM_BYTES.
  - A beat is a cycle with src_valid & src_ready.
  - On a beat: in the next cycle load=1 and store=src_data (one-cycle latency), and byte_count and checksum update on the same edge as the load pulse. load is exactly one cycle per beat; back-to-back beats give back-to-back load pulses.
  - On a beat with src_last=1: go to RUN. The final load pulse coincides with the first RUN cycle.
  - boot_start during LOAD: ignored.
- Overflow: src_valid while byte_count == MEM_BYTES → ERROR. No load pulse; src_ready is already 0 at that point. An overflow byte flagged src_last still goes to ERROR (error wins).
- RUN:
  - ready=1, cpu_stall=0.
  - mem_read = cpu_mem_read & ready and mem_write = cpu_mem_write & ready, both combinational.
  - boot_done=1 in the first RUN cycle only.
  - boot_start in RUN: go to LOAD. ready drops on that edge and no CPU access is forwarded from the next cycle on. byte_count and checksum clear.
- ERROR: boot_error=1, ready=0, cpu_stall=1, src_ready=0. Only boot_start (go to LOAD) or reset leaves ERROR.
- Outside RUN: mem_read=mem_write=0 regardless of CPU inputs.
- Reset asserted mid-LOAD: immediately return to IDLE with reset values. A pending load pulse is dropped.
- Arithmetic:
  - byte_count saturates at MEM_BYTES and never wraps.
  - checksum wraps modulo 256.

Decomposition:
- Shared package: state enum (IDLE, LOAD, RUN, ERROR), MEM_BYTES default, byte width constant 8.
- No sub-module needed. The gating logic is inline; the FSM plus the count/checksum datapath stays in one module.

Test Plan:
- Reset then boot_start, stream bytes 0x11, 0x22, 0x33 (last on 0x33) with src_valid held → three consecutive load pulses, store 0x11/0x22/0x33 one cycle after each beat; byte_count=3, checksum=0x66, boot_done pulses once, ready=1, cpu_stall=0.
- Stream with src_valid toggling (gaps of 2 cycles) → load pulses only after accepted beats; no pulse in gap cycles.
- In RUN, cpu_mem_write=1 → mem_write=1 the same cycle. Before boot (IDLE/LOAD), cpu_mem_write=1 and cpu_mem_read=1 → mem_write=0, mem_read=0, cpu_stall=1.
- Stream MEM_BYTES bytes without src_last, then one more valid byte → src_ready=0 after the 1024th beat; ERROR with boot_error=1, ready=0, byte_count=1024, no 1025th load.
- In RUN, assert boot_start → ready=0 next cycle, byte_count=0, checksum=0. Reload 0xFF, 0x02 (last) → checksum=0x01, back to RUN.
- Assert rst_n=0 mid-LOAD after 5 beats → all outputs at reset values asynchronously; no further load pulse after release.
